pixel_row_assembler: RTL and testbench

// Upstream feeder for the input-image BRAM loader. Accepts a serial 8-bit pixel stream
// (valid/ready) and packs it into 28-pixel rows using two ping-pong row buffers.

---
 rtl/pixel_row_assembler.sv | 159 +++++++++++++++
 tb/tb_pixel_row_assembler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_row_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_row_assembler                                                        |
// | Packs a serial pixel stream into ping-pong row banks and hands full rows   |
// | to the BRAM loader with their base address.                                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pixel_row_assembler #(
  parameter int ROW_LEN    = 28,
  parameter int ROWS       = 28,
  parameter int ADDR_W     = 11,
  parameter int BASE_ADDR  = 10,
  parameter int NORM_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rescale,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  load_en,
  output logic [8*ROW_LEN-1:0]  row_data,
  output logic [ADDR_W-1:0]     row_addr,
  input  logic                  load_done,
  output logic [4:0]            row_idx,
  output logic                  frame_done
);

  localparam int              c_cnt_w    = $clog2(ROW_LEN);
  localparam logic [1:0]      c_idle     = 2'd0;
  localparam logic [1:0]      c_present  = 2'd1;
  localparam logic [1:0]      c_gap      = 2'd2;
  localparam logic [ADDR_W-1:0]  c_base     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  c_row_len  = ADDR_W'(ROW_LEN);
  localparam logic [c_cnt_w-1:0] c_last_pix = c_cnt_w'(ROW_LEN - 1);
  localparam logic [4:0]         c_last_row = 5'(ROWS - 1);

  logic [7:0]            bank_q [2][ROW_LEN];
  logic [7:0]            bank_d [2][ROW_LEN];
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [c_cnt_w-1:0]    pix_cnt_q, pix_cnt_d;
  logic [1:0]            state_q, state_d;
  logic [8*ROW_LEN-1:0]  row_data_q, row_data_d;
  logic [ADDR_W-1:0]     row_addr_q, row_addr_d;
  logic [4:0]            row_idx_q, row_idx_d;
  logic                  frame_done_q, frame_done_d;
  logic                  accept;
  logic                  row_freed;
  logic [7:0]            pix_norm;

  // Gated by rst so nothing is accepted while the block is held in reset.
  assign in_ready  = rst & ~full_q[wr_bank_q];
  assign accept    = in_valid & in_ready;
  assign pix_norm  = in_data >> NORM_SHIFT;
  assign row_freed = (state_q == c_present) & load_done & ~rescale;

  // Write side: fill the write bank, then flip to the other one.
  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    pix_cnt_d = pix_cnt_q;
    if (row_freed) full_d[rd_bank_q] = 1'b0;
    if (accept) begin
      bank_d[wr_bank_q][pix_cnt_q] = pix_norm;
      if (pix_cnt_q == c_last_pix) begin
        full_d[wr_bank_q] = 1'b1;
        pix_cnt_d         = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        pix_cnt_d = pix_cnt_q + c_cnt_w'(1);
      end
    end
    if (rescale) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      pix_cnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:    if (full_q[rd_bank_q]) state_d = c_present;
      c_present: if (load_done) state_d = c_gap;
      c_gap:     state_d = c_idle;
      default:   state_d = c_idle;
    endcase
    if (rescale) state_d = c_idle;
  end

  // Read side: banks alternate, so the oldest full bank is always rd_bank.
  always_comb begin
    row_data_d   = row_data_q;
    row_addr_d   = row_addr_q;
    row_idx_d    = row_idx_q;
    rd_bank_d    = rd_bank_q;
    frame_done_d = 1'b0;
    if ((state_q == c_idle) && full_q[rd_bank_q]) begin
      for (int k = 0; k < ROW_LEN; k++) row_data_d[8*k +: 8] = bank_q[rd_bank_q][k];
      row_addr_d = c_base + ADDR_W'(row_idx_q) * c_row_len;
    end
    if (row_freed) begin
      rd_bank_d = ~rd_bank_q;
      if (row_idx_q == c_last_row) begin
        row_idx_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        row_idx_d = row_idx_q + 5'd1;
      end
    end
    if (rescale) begin
      row_idx_d = '0;
      rd_bank_d = 1'b0;
    end
  end

  always_comb begin
    load_en = (state_q == c_present);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= c_idle;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q       <= '{default: '{default: 8'h00}};
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      pix_cnt_q    <= '0;
      row_data_q   <= '0;
      row_addr_q   <= c_base;
      row_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      pix_cnt_q    <= pix_cnt_d;
      row_data_q   <= row_data_d;
      row_addr_q   <= row_addr_d;
      row_idx_q    <= row_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_data   = row_data_q;
  assign row_addr   = row_addr_q;
  assign row_idx    = row_idx_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_row_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pixel_row_assembler                                                     |
// | Self-checking bench: row-queue reference model plus directed sequences.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_pixel_row_assembler;

  localparam int ROW_LEN = 28;
  localparam int ROWS    = 28;
  localparam int BASE    = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rescale = 1'b0, in_valid = 1'b0, load_done = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, load_en, frame_done;
  logic [8*ROW_LEN-1:0] row_data;
  logic [10:0] row_addr;
  logic [4:0] row_idx;

  logic ns_rescale = 1'b0, ns_in_valid = 1'b0, ns_load_done = 1'b0;
  logic [7:0] ns_in_data = 8'h00;
  logic ns_in_ready, ns_load_en, ns_frame_done;
  logic [8*ROW_LEN-1:0] ns_row_data;
  logic [10:0] ns_row_addr;
  logic [4:0] ns_row_idx;

  always #5 clk = ~clk;

  pixel_row_assembler dut (
    .clk(clk), .rst(rst), .rescale(rescale), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load_en(load_en), .row_data(row_data), .row_addr(row_addr),
    .load_done(load_done), .row_idx(row_idx), .frame_done(frame_done)
  );

  pixel_row_assembler #(.NORM_SHIFT(1)) dut_ns (
    .clk(clk), .rst(rst), .rescale(ns_rescale), .in_valid(ns_in_valid), .in_data(ns_in_data),
    .in_ready(ns_in_ready), .load_en(ns_load_en), .row_data(ns_row_data), .row_addr(ns_row_addr),
    .load_done(ns_load_done), .row_idx(ns_row_idx), .frame_done(ns_frame_done)
  );

  typedef struct {
    logic [7:0] pix;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[6];

  int total = 0;
  int bad = 0;

  // Reference model: pixels of the row being filled, and complete rows not yet loaded.
  logic [7:0] cur_row[$];
  logic [8*ROW_LEN-1:0] exp_rows[$];
  int served = 0;
  logic fd_exp = 1'b0;
  int fd_count = 0;
  logic prev_load_en = 1'b0;
  logic last_acc = 1'b0;
  int ld_policy = 0;   // 0 never, 1 fixed delay, 2 random
  int ld_delay = 0;
  int ld_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    cur_row.delete();
    exp_rows.delete();
    served = 0;
    fd_exp = 1'b0;
    prev_load_en = 1'b0;
    ld_cnt = 0;
  endtask

  task automatic set_loader();
    if (ld_policy == 2) begin
      load_done = ($urandom % 3) == 0;
    end else if (load_en && ld_policy == 1) begin
      load_done = (ld_cnt >= ld_delay);
      ld_cnt++;
    end else begin
      load_done = 1'b0;
      ld_cnt = 0;
    end
  endtask

  task automatic tick();
    logic acc, done;
    logic [8*ROW_LEN-1:0] r;
    set_loader();
    acc  = in_valid && in_ready && !rescale;
    done = load_done && load_en && !rescale;
    @(posedge clk);
    #1;
    last_acc = acc;
    fd_exp = 1'b0;
    if (rescale) begin
      model_clear();
      check("rescale_load_en_low", load_en, 0);
    end else begin
      if (acc) begin
        cur_row.push_back(in_data);
        if (cur_row.size() == ROW_LEN) begin
          for (int k = 0; k < ROW_LEN; k++) r[8*k +: 8] = cur_row[k];
          exp_rows.push_back(r);
          cur_row.delete();
        end
      end
      if (done) begin
        void'(exp_rows.pop_front());
        if (served == ROWS - 1) begin
          served = 0;
          fd_exp = 1'b1;
        end else begin
          served++;
        end
        check("load_en_low_after_done", load_en, 0);
      end
    end
    check("frame_done", frame_done, fd_exp);
    if (frame_done) fd_count++;
    check("row_idx", row_idx, served);
    check("in_ready", in_ready, exp_rows.size() < 2);
    if (load_en && !prev_load_en) begin
      check("row_pending", exp_rows.size() > 0, 1);
      if (exp_rows.size() > 0) begin
        check("row_data", row_data, exp_rows[0]);
        check("row_addr", row_addr, BASE + ROW_LEN * served);
      end
    end
    prev_load_en = load_en;
  endtask

  task automatic stream(input int n, input int budget, input string name, input bit seq);
    int sent = 0;
    int cyc = 0;
    while (sent < n && cyc < budget) begin
      in_valid = 1'b1;
      in_data = seq ? 8'(sent + 1) : 8'($urandom);
      tick();
      if (last_acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    check({name, "_sent"}, sent, n);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int cyc = 0;
    while (exp_rows.size() != 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    check({name, "_drained"}, exp_rows.size() == 0, 1);
  endtask

  task automatic pulse_rescale(input logic with_valid);
    rescale = 1'b1;
    in_valid = with_valid;
    tick();
    rescale = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    int cyc;
    logic seen;

    tbl[0] = '{pix: 8'hFF, exp: 8'h7F};
    tbl[1] = '{pix: 8'h80, exp: 8'h40};
    tbl[2] = '{pix: 8'h01, exp: 8'h00};
    tbl[3] = '{pix: 8'h03, exp: 8'h01};
    tbl[4] = '{pix: 8'hFE, exp: 8'h7F};
    tbl[5] = '{pix: 8'h00, exp: 8'h00};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("in_ready_in_reset", in_ready, 0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_load_en", load_en, 0);
    check("rst_row_data", row_data, 0);
    check("rst_row_addr", row_addr, BASE);
    check("rst_row_idx", row_idx, 0);
    check("rst_frame_done", frame_done, 0);

    // 1: single row, loader answers 3 cycles after load_en
    ld_policy = 1; ld_delay = 3;
    stream(ROW_LEN, 40, "t1", 1'b1);
    check("t1_load_en_edge_n", load_en, 0);
    tick();
    check("t1_load_en_edge_n1", load_en, 1);
    check("t1_row_addr", row_addr, BASE);
    check("t1_pix0", row_data[7:0], 1);
    check("t1_pix27", row_data[8*27 +: 8], 28);
    wait_drain(20, "t1");
    check("t1_row_idx", row_idx, 1);

    // 2: back-pressure with both banks full
    ld_policy = 0;
    acc_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      tick();
      if (last_acc) acc_cnt++;
    end
    check("t2_accepted_before_stall", acc_cnt, 2 * ROW_LEN);
    check("t2_in_ready_stalled", in_ready, 0);
    ld_policy = 1; ld_delay = 0;
    cyc = 0;
    while (acc_cnt < 3 * ROW_LEN && cyc < 300) begin
      in_data = 8'($urandom);
      tick();
      if (last_acc) acc_cnt++;
      cyc++;
    end
    in_valid = 1'b0;
    check("t2_accepted_total", acc_cnt, 3 * ROW_LEN);
    wait_drain(300, "t2");

    // 3: full frame from row 0
    pulse_rescale(1'b0);
    fd_count = 0;
    ld_policy = 1; ld_delay = 2;
    stream(ROWS * ROW_LEN, 3000, "t3", 1'b0);
    wait_drain(100, "t3");
    check("t3_frame_done_pulses", fd_count, 1);
    check("t3_row_idx_wrapped", row_idx, 0);

    // 4: rescale mid-row 3, then rescale while presenting
    ld_delay = 1;
    stream(3 * ROW_LEN, 400, "t4a", 1'b0);
    wait_drain(100, "t4a");
    stream(15, 40, "t4b", 1'b0);
    pulse_rescale(1'b1);
    check("t4_row_idx_after_rescale", row_idx, 0);
    stream(ROW_LEN, 60, "t4c", 1'b1);
    tick();
    check("t4_restart_load_en", load_en, 1);
    check("t4_restart_addr", row_addr, BASE);
    check("t4_restart_pix0", row_data[7:0], 1);
    wait_drain(20, "t4c");
    ld_policy = 0;
    stream(ROW_LEN, 60, "t4d", 1'b0);
    cyc = 0;
    while (!load_en && cyc < 10) begin
      tick();
      cyc++;
    end
    check("t4d_load_en_up", load_en, 1);
    pulse_rescale(1'b0);
    check("t4d_load_en_dropped", load_en, 0);

    // 5: asynchronous reset in the middle of PRESENT
    stream(ROW_LEN, 60, "t5", 1'b0);
    cyc = 0;
    while (!load_en && cyc < 10) begin
      tick();
      cyc++;
    end
    check("t5_load_en_up", load_en, 1);
    #2 rst = 1'b0;
    #1;
    check("t5_async_load_en", load_en, 0);
    check("t5_async_row_data", row_data, 0);
    check("t5_async_frame_done", frame_done, 0);
    check("t5_async_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("t5_held_in_ready", in_ready, 0);
    rst = 1'b1;
    model_clear();
    #1;
    check("t5_release_in_ready", in_ready, 1);
    check("t5_release_row_addr", row_addr, BASE);

    // 6: NORM_SHIFT=1 instance, table-driven pixel values
    for (int k = 0; k < ROW_LEN; k++) begin
      ns_in_valid = 1'b1;
      ns_in_data = tbl[k % 6].pix;
      @(posedge clk);
      #1;
    end
    ns_in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (ns_load_en) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("t6_load_en", ns_load_en, 1);
    for (int k = 0; k < ROW_LEN; k++)
      check($sformatf("t6_pix%0d", k), ns_row_data[8*k +: 8], tbl[k % 6].exp);
    ns_load_done = 1'b1;
    @(posedge clk);
    #1;
    ns_load_done = 1'b0;
    check("t6_load_en_low", ns_load_en, 0);

    // Randomized traffic against the row-queue model
    ld_policy = 2;
    for (int c = 0; c < 4000; c++) begin
      in_valid = ($urandom % 4) != 0;
      in_data = 8'($urandom);
      rescale = ($urandom % 500) == 0;
      tick();
    end
    rescale = 1'b0;
    in_valid = 1'b0;
    ld_policy = 1; ld_delay = 1;
    wait_drain(100, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
